tbl_port_arbiter: RTL and testbench

Shares one external table's read/write port (req/ack handshake, one row of `TBL_NUM_COLS` 32-bit cells) between `NUM_REQ` requesters, e.g. the register-interface table bridge and a datapath learning/update engine. Requests are granted round-robin, and only one table operation is outstanding at a time. Addresses and data are latched at grant, and the table acknowledge is routed back to the granted requester as a one-cycle pulse. It sits between the requesters' table ports and the table implementation.

---
 rtl/tbl_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_tbl_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tbl_port_arbiter.sv
// Round-robin arbiter that shares one table read/write port between NUM_REQ requesters.
// One table operation is in flight at a time. Each operation runs IDLE -> ISSUE -> DONE.
module tbl_port_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_NUM_COLS       = 4,
    parameter int TBL_NUM_ROWS       = 16,
    parameter int NUM_REQ            = 2,
    localparam int DW = C_S_AXI_DATA_WIDTH * TBL_NUM_COLS,
    localparam int AW = $clog2(TBL_NUM_ROWS),
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Resetn,
    input  logic [NUM_REQ-1:0]    req_rd_req,
    input  logic [NUM_REQ*AW-1:0] req_rd_addr,
    output logic [NUM_REQ-1:0]    req_rd_ack,
    output logic [DW-1:0]         req_rd_data,
    input  logic [NUM_REQ-1:0]    req_wr_req,
    input  logic [NUM_REQ*AW-1:0] req_wr_addr,
    input  logic [NUM_REQ*DW-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]    req_wr_ack,
    output logic                  tbl_rd_req,
    input  logic                  tbl_rd_ack,
    output logic [AW-1:0]         tbl_rd_addr,
    input  logic [DW-1:0]         tbl_rd_data,
    output logic                  tbl_wr_req,
    input  logic                  tbl_wr_ack,
    output logic [AW-1:0]         tbl_wr_addr,
    output logic [DW-1:0]         tbl_wr_data,
    output logic                  busy,
    output logic [GW-1:0]         grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        last_grant;
    logic                 op_wr;
    logic [NUM_REQ-1:0]   elig;
    logic                 hi_vld, lo_vld, win_vld, win_wr, ack_match;
    logic [GW-1:0]        hi_id, lo_id, win_id;

    assign elig = req_rd_req | req_wr_req;

    // Lowest eligible index above last_grant wins; otherwise wrap to the lowest eligible.
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        lo_vld = 1'b0;
        lo_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_vld = 1'b1;
                lo_id  = GW'(i);
                if (i > int'(last_grant)) begin
                    hi_vld = 1'b1;
                    hi_id  = GW'(i);
                end
            end
        end
    end

    assign win_vld   = hi_vld | lo_vld;
    assign win_id    = hi_vld ? hi_id : lo_id;
    assign win_wr    = req_wr_req[win_id];
    assign ack_match = op_wr ? tbl_wr_ack : tbl_rd_ack;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) state <= S_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = win_vld ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nxt = ack_match ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Acks and read data are registered on the ISSUE->DONE edge, so they are visible during DONE.
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            last_grant  <= GW'(NUM_REQ - 1);
            grant_id    <= '0;
            op_wr       <= 1'b0;
            tbl_rd_req  <= 1'b0;
            tbl_wr_req  <= 1'b0;
            tbl_rd_addr <= '0;
            tbl_wr_addr <= '0;
            tbl_wr_data <= '0;
            req_rd_data <= '0;
            req_rd_ack  <= '0;
            req_wr_ack  <= '0;
        end else begin
            req_rd_ack <= '0;
            req_wr_ack <= '0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        grant_id   <= win_id;
                        last_grant <= win_id;
                        op_wr      <= win_wr;
                        if (win_wr) begin
                            tbl_wr_addr <= req_wr_addr[int'(win_id)*AW +: AW];
                            tbl_wr_data <= req_wr_data[int'(win_id)*DW +: DW];
                            tbl_wr_req  <= 1'b1;
                        end else begin
                            tbl_rd_addr <= req_rd_addr[int'(win_id)*AW +: AW];
                            tbl_rd_req  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ack_match) begin
                        tbl_rd_req <= 1'b0;
                        tbl_wr_req <= 1'b0;
                        if (op_wr) begin
                            req_wr_ack[grant_id] <= 1'b1;
                        end else begin
                            req_rd_ack[grant_id] <= 1'b1;
                            req_rd_data          <= tbl_rd_data;
                        end
                    end
                end
                default: begin
                    tbl_rd_req <= 1'b0;
                    tbl_wr_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tbl_port_arbiter.sv
// Randomized bench for tbl_port_arbiter. The bench acts as both the requesters and the table.
// A transaction-level model predicts each grant, the table-side request and the result returned.
module tb_tbl_port_arbiter;
    localparam int CW = 32, NC = 4, ROWS = 16, NR = 2;
    localparam int DW = CW * NC, AW = $clog2(ROWS), GW = $clog2(NR);

    logic                 Bus2IP_Clk, Bus2IP_Resetn;
    logic [NR-1:0]        req_rd_req, req_wr_req, req_rd_ack, req_wr_ack;
    logic [NR*AW-1:0]     req_rd_addr, req_wr_addr;
    logic [NR*DW-1:0]     req_wr_data;
    logic [DW-1:0]        req_rd_data, tbl_rd_data, tbl_wr_data;
    logic                 tbl_rd_req, tbl_rd_ack, tbl_wr_req, tbl_wr_ack, busy;
    logic [AW-1:0]        tbl_rd_addr, tbl_wr_addr;
    logic [GW-1:0]        grant_id;

    logic [AW-1:0]        rd_a [NR];
    logic [AW-1:0]        wr_a [NR];
    logic [DW-1:0]        wr_d [NR];
    logic [DW-1:0]        mem  [ROWS];
    logic [DW-1:0]        exp_rdd;
    int                   last, n_cmp, n_bad;

    tbl_port_arbiter #(.C_S_AXI_DATA_WIDTH(CW), .TBL_NUM_COLS(NC), .TBL_NUM_ROWS(ROWS), .NUM_REQ(NR)) dut (
        .Bus2IP_Clk(Bus2IP_Clk), .Bus2IP_Resetn(Bus2IP_Resetn),
        .req_rd_req(req_rd_req), .req_rd_addr(req_rd_addr), .req_rd_ack(req_rd_ack),
        .req_rd_data(req_rd_data), .req_wr_req(req_wr_req), .req_wr_addr(req_wr_addr),
        .req_wr_data(req_wr_data), .req_wr_ack(req_wr_ack),
        .tbl_rd_req(tbl_rd_req), .tbl_rd_ack(tbl_rd_ack), .tbl_rd_addr(tbl_rd_addr),
        .tbl_rd_data(tbl_rd_data), .tbl_wr_req(tbl_wr_req), .tbl_wr_ack(tbl_wr_ack),
        .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .busy(busy), .grant_id(grant_id)
    );

    initial Bus2IP_Clk = 1'b0;
    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    always_comb begin
        req_rd_addr = '0;
        req_wr_addr = '0;
        req_wr_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_rd_addr[i*AW +: AW] = rd_a[i];
            req_wr_addr[i*AW +: AW] = wr_a[i];
            req_wr_data[i*DW +: DW] = wr_d[i];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++) r[c*CW +: CW] = $urandom;
        return r;
    endfunction

    // Scan upward from last+1 with wrap; the first requester holding any request wins.
    function automatic int pick(input int lst, input logic [NR-1:0] e);
        for (int off = 1; off <= NR; off++)
            if (e[GW'((lst + off) % NR)]) return (lst + off) % NR;
        return -1;
    endfunction

    task automatic step();
        @(posedge Bus2IP_Clk);
        #1;
        tbl_rd_data = rand_row();
    endtask

    task automatic add_reqs();
        for (int i = 0; i < NR; i++) begin
            if (!req_wr_req[i] && ($urandom % 2 == 0)) begin
                req_wr_req[i] = 1'b1;
                wr_a[i] = AW'($urandom_range(0, ROWS - 1));
                wr_d[i] = rand_row();
            end
            if (!req_rd_req[i] && ($urandom % 2 == 0)) begin
                req_rd_req[i] = 1'b1;
                rd_a[i] = (req_wr_req[i] && $urandom % 2 == 0) ? wr_a[i]
                                                                : AW'($urandom_range(0, ROWS - 1));
            end
        end
    endtask

    task automatic do_op();
        int w, lat;
        logic isw;
        logic [AW-1:0] a;
        w = pick(last, req_rd_req | req_wr_req);
        if (w < 0) begin
            tbl_rd_ack = ($urandom % 2 == 0);
            step();
            tbl_rd_ack = 1'b0;
            chk("idle_busy", DW'(busy), '0);
            chk("idle_tbl_req", DW'({tbl_rd_req, tbl_wr_req}), '0);
            chk("idle_ack", DW'({req_rd_ack, req_wr_ack}), '0);
            return;
        end
        isw = req_wr_req[w];
        a = isw ? wr_a[w] : rd_a[w];
        step();
        chk("grant_id", DW'(grant_id), DW'(w));
        chk("issue_busy", DW'(busy), DW'(1));
        chk("tbl_req", DW'({tbl_rd_req, tbl_wr_req}), isw ? DW'(2'b01) : DW'(2'b10));
        if (isw) begin
            chk("tbl_wr_addr", DW'(tbl_wr_addr), DW'(a));
            chk("tbl_wr_data", tbl_wr_data, wr_d[w]);
        end else begin
            chk("tbl_rd_addr", DW'(tbl_rd_addr), DW'(a));
        end
        lat = $urandom_range(0, 3);
        repeat (lat) begin
            if ($urandom % 2 == 0) begin
                if (isw) tbl_rd_ack = 1'b1;
                else     tbl_wr_ack = 1'b1;
            end
            step();
            tbl_rd_ack = 1'b0;
            tbl_wr_ack = 1'b0;
            chk("wait_tbl_req", DW'({tbl_rd_req, tbl_wr_req}), isw ? DW'(2'b01) : DW'(2'b10));
            chk("wait_ack", DW'({req_rd_ack, req_wr_ack}), '0);
        end
        if (isw) tbl_wr_ack = 1'b1;
        else begin
            tbl_rd_ack  = 1'b1;
            tbl_rd_data = mem[a];
        end
        step();
        tbl_rd_ack = 1'b0;
        tbl_wr_ack = 1'b0;
        if (isw) mem[a] = wr_d[w];
        else     exp_rdd = mem[a];
        chk("done_tbl_req", DW'({tbl_rd_req, tbl_wr_req}), '0);
        chk("done_wr_ack", DW'(req_wr_ack), isw ? DW'(1) << w : '0);
        chk("done_rd_ack", DW'(req_rd_ack), isw ? '0 : DW'(1) << w);
        chk("rd_data", req_rd_data, exp_rdd);
        chk("done_busy", DW'(busy), DW'(1));
        if ($urandom % 3 == 0) tbl_rd_ack = 1'b1;
        step();
        tbl_rd_ack = 1'b0;
        chk("post_ack", DW'({req_rd_ack, req_wr_ack}), '0);
        chk("post_busy", DW'(busy), '0);
        chk("post_rd_data", req_rd_data, exp_rdd);
        if (isw) req_wr_req[w] = 1'b0;
        else     req_rd_req[w] = 1'b0;
        last = w;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last = NR - 1;
        exp_rdd = '0;
        for (int r = 0; r < ROWS; r++) mem[r] = rand_row();
        tbl_rd_ack = 1'b0;
        tbl_wr_ack = 1'b0;
        tbl_rd_data = '0;
        Bus2IP_Resetn = 1'b0;
        req_rd_req = '1;
        req_wr_req = '1;
        for (int i = 0; i < NR; i++) begin
            rd_a[i] = AW'(i + 3);
            wr_a[i] = AW'(i + 1);
            wr_d[i] = rand_row();
        end
        repeat (3) step();
        chk("rst_tbl_req", DW'({tbl_rd_req, tbl_wr_req}), '0);
        chk("rst_req_ack", DW'({req_rd_ack, req_wr_ack}), '0);
        chk("rst_addr", DW'({tbl_rd_addr, tbl_wr_addr}), '0);
        chk("rst_wr_data", tbl_wr_data, '0);
        chk("rst_rd_data", req_rd_data, '0);
        chk("rst_busy_gid", DW'({busy, grant_id}), '0);
        Bus2IP_Resetn = 1'b1;

        repeat (150) begin
            if ($urandom % 4 != 0) add_reqs();
            do_op();
        end

        // Reset while a read is outstanding; the table's late ack must be ignored.
        req_rd_req = '0;
        req_wr_req = '0;
        req_rd_req[NR-1] = 1'b1;
        rd_a[NR-1] = AW'(7);
        step();
        chk("mid_tbl_rd_req", DW'(tbl_rd_req), DW'(1));
        Bus2IP_Resetn = 1'b0;
        req_rd_req = '0;
        step();
        Bus2IP_Resetn = 1'b1;
        tbl_rd_ack = 1'b1;
        step();
        tbl_rd_ack = 1'b0;
        last = NR - 1;
        exp_rdd = '0;
        chk("mid_busy", DW'(busy), '0);
        chk("mid_tbl_req", DW'({tbl_rd_req, tbl_wr_req}), '0);
        step();
        chk("mid_req_ack", DW'({req_rd_ack, req_wr_ack}), '0);
        chk("mid_rd_data", req_rd_data, '0);

        repeat (60) begin
            if ($urandom % 4 != 0) add_reqs();
            do_op();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
